// File: rtl/axi_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_sram_slave: AXI3 32-bit slave memory model, one outstanding burst per  |
// | direction, independent read and write engines.      Revision: 1.0          |
// +----------------------------------------------------------------------------+
module axi_sram_slave #(
  parameter int MEM_AW     = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int         c_DEPTH     = 1 << MEM_AW;
  localparam logic [2:0] c_WAIT_LAST = (RD_LATENCY > 0) ? 3'(RD_LATENCY - 1) : 3'd0;
  localparam logic [1:0] c_OKAY      = 2'b00;
  localparam logic [1:0] c_SLVERR    = 2'b10;
  localparam logic [1:0] c_DECERR    = 2'b11;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;

  function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] inc;
    logic [31:0] mask;
    logic        wrap_ok;
    inc     = 32'd1 << size;
    mask    = (({28'd0, len} + 32'd1) << size) - 32'd1;
    wrap_ok = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    case (burst)
      2'b00:   f_next_addr = addr;
      2'b10:   f_next_addr = wrap_ok ? ((addr & ~mask) | ((addr + inc) & mask)) : (addr + inc);
      default: f_next_addr = addr + inc;
    endcase
  endfunction

  function automatic logic f_bad(input logic [2:0] size, input logic [1:0] burst);
    f_bad = (size > 3'd2) || (burst == 2'b11);
  endfunction

  function automatic logic f_oor(input logic [31:0] addr);
    f_oor = (addr >> (MEM_AW + 2)) != 32'd0;
  endfunction

  logic [31:0] r_mem [0:c_DEPTH-1];
  logic        r_live;

  // ---------------------------------------------------------------- read engine
  rstate_t     r_rstate, w_rstate_nxt;
  logic [3:0]  r_rid;
  logic [31:0] r_raddr;
  logic [3:0]  r_rlen;
  logic [2:0]  r_rsize;
  logic [1:0]  r_rburst;
  logic [3:0]  r_rbeat;
  logic [2:0]  r_rwcnt;
  logic        r_rvalid;
  logic        r_rlast;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic        w_ar_hs, w_wait_done, w_rd_adv, w_rd_start_ld, w_rload;
  logic [31:0] w_raddr_nxt, w_ld_addr;
  logic [3:0]  w_ld_len, w_ld_beat;
  logic [2:0]  w_ld_size;
  logic [1:0]  w_ld_burst;
  logic [31:0] w_ld_data;
  logic [1:0]  w_ld_resp;
  logic        w_ld_last;
  logic [MEM_AW-1:0] w_ld_idx;

  assign arready       = (r_rstate == R_IDLE) && r_live;
  assign w_ar_hs       = arvalid && arready;
  assign w_wait_done   = (r_rstate == R_WAIT) && (r_rwcnt == c_WAIT_LAST);
  assign w_rd_adv      = r_rvalid && rready && !r_rlast;
  assign w_rd_start_ld = (RD_LATENCY == 0) && w_ar_hs;
  assign w_rload       = w_rd_start_ld || w_wait_done || w_rd_adv;
  assign w_raddr_nxt   = f_next_addr(r_raddr, r_rlen, r_rsize, r_rburst);

  // The beat being loaded comes from the AR bus (zero latency), the latched
  // start address (end of wait) or the advanced address (next beat).
  always_comb begin
    w_ld_addr  = r_raddr;
    w_ld_len   = r_rlen;
    w_ld_size  = r_rsize;
    w_ld_burst = r_rburst;
    w_ld_beat  = 4'd0;
    if (w_rd_start_ld) begin
      w_ld_addr  = araddr;
      w_ld_len   = arlen[3:0];
      w_ld_size  = arsize;
      w_ld_burst = arburst;
    end else if (w_rd_adv) begin
      w_ld_addr  = w_raddr_nxt;
      w_ld_beat  = r_rbeat + 4'd1;
    end
  end

  assign w_ld_idx  = w_ld_addr[MEM_AW+1:2];
  assign w_ld_last = (w_ld_beat == w_ld_len);

  always_comb begin
    w_ld_data = 32'd0;
    w_ld_resp = c_OKAY;
    if (f_bad(w_ld_size, w_ld_burst)) begin
      w_ld_resp = c_SLVERR;
    end else if (f_oor(w_ld_addr)) begin
      w_ld_resp = c_DECERR;
    end else begin
      w_ld_data = r_mem[w_ld_idx];
    end
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = (RD_LATENCY > 0) ? R_WAIT : R_DATA;
      R_WAIT:  if (w_wait_done) w_rstate_nxt = R_DATA;
      R_DATA:  if (r_rvalid && rready && r_rlast) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rstate <= R_IDLE;
      r_live   <= 1'b0;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_live   <= 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rsize  <= '0;
      r_rburst <= '0;
      r_rbeat  <= '0;
      r_rwcnt  <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      if (w_ar_hs) begin
        r_rid    <= arid;
        r_raddr  <= araddr;
        r_rlen   <= arlen[3:0];
        r_rsize  <= arsize;
        r_rburst <= arburst;
        r_rbeat  <= 4'd0;
        r_rwcnt  <= 3'd0;
      end
      if ((r_rstate == R_WAIT) && !w_wait_done) begin
        r_rwcnt <= r_rwcnt + 3'd1;
      end
      if (w_rd_adv) begin
        r_raddr <= w_raddr_nxt;
        r_rbeat <= r_rbeat + 4'd1;
      end
      if (w_rload) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_ld_data;
        r_rresp  <= w_ld_resp;
        r_rlast  <= w_ld_last;
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end
  end

  assign rid    = r_rid;
  assign rdata  = r_rdata;
  assign rresp  = r_rresp;
  assign rlast  = r_rlast;
  assign rvalid = r_rvalid;

  // --------------------------------------------------------------- write engine
  wstate_t     r_wstate, w_wstate_nxt;
  logic [3:0]  r_wid;
  logic [31:0] r_waddr;
  logic [3:0]  r_wlen;
  logic [2:0]  r_wsize;
  logic [1:0]  r_wburst;
  logic [3:0]  r_wbeat;
  logic        r_wbad;
  logic        r_werr;
  logic        r_wdec;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic [3:0]  r_bid;

  logic        w_aw_hs, w_w_hs, w_wbeat_last, w_beat_err, w_beat_oor, w_mem_we;
  logic [MEM_AW-1:0] w_widx;

  assign awready      = (r_wstate == W_IDLE) && r_live;
  assign wready       = (r_wstate == W_DATA);
  assign w_aw_hs      = awvalid && awready;
  assign w_w_hs       = wvalid && wready;
  assign w_wbeat_last = (r_wbeat == r_wlen);
  assign w_beat_err   = (wlast != w_wbeat_last) || (wid != r_wid);
  assign w_beat_oor   = f_oor(r_waddr);
  assign w_mem_we     = w_w_hs && !r_wbad && !w_beat_oor;
  assign w_widx       = r_waddr[MEM_AW+1:2];

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
      W_DATA:  if (w_w_hs && w_wbeat_last) w_wstate_nxt = W_RESP;
      W_RESP:  if (r_bvalid && bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_nxt;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wsize  <= '0;
      r_wburst <= '0;
      r_wbeat  <= '0;
      r_wbad   <= 1'b0;
      r_werr   <= 1'b0;
      r_wdec   <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= '0;
      r_bid    <= '0;
    end else begin
      if (w_aw_hs) begin
        r_wid    <= awid;
        r_bid    <= awid;
        r_waddr  <= awaddr;
        r_wlen   <= awlen[3:0];
        r_wsize  <= awsize;
        r_wburst <= awburst;
        r_wbeat  <= 4'd0;
        r_wbad   <= f_bad(awsize, awburst);
        r_werr   <= 1'b0;
        r_wdec   <= 1'b0;
      end
      if (w_w_hs) begin
        r_waddr <= f_next_addr(r_waddr, r_wlen, r_wsize, r_wburst);
        r_wbeat <= r_wbeat + 4'd1;
        r_werr  <= r_werr | w_beat_err;
        r_wdec  <= r_wdec | w_beat_oor;
        // The response folds in the final beat's own flags, which are not yet registered.
        if (w_wbeat_last) begin
          r_bvalid <= 1'b1;
          if (r_werr || w_beat_err || r_wbad) begin
            r_bresp <= c_SLVERR;
          end else if (r_wdec || w_beat_oor) begin
            r_bresp <= c_DECERR;
          end else begin
            r_bresp <= c_OKAY;
          end
        end
      end
      if (r_bvalid && bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // Storage has no reset so contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (w_mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          r_mem[w_widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign bid    = r_bid;
  assign bresp  = r_bresp;
  assign bvalid = r_bvalid;

  logic w_unused;
  assign w_unused = &{1'b0, arlen[7:4], awlen[7:4]};

endmodule
`default_nettype wire
